serial_hex_tx: RTL and testbench
================================

// Module: serial_hex_tx
// PURPOSE
//  Transmit-side counterpart of the serial seven-segment receiver path: sends a latched
//  DATA_W-bit value as uppercase ASCII hex followed by CR LF over an 8N1 UART line.
//  Sits in a board top; DATA_IN is typically wired to switches and SEND to a debounced button.
//  It is the transmitter for the same line format the receiver decodes.
// PARAMETERS
//  CLK_FREQ  100_000_000  input clock frequency in Hz
//  BAUD      9600         line rate; bit period DIV = CLK_FREQ/BAUD cycles (integer, truncated)
//  DATA_W    16           payload width; must be a multiple of 4; NCHAR = DATA_W/4 hex digits
// PORTS
//  CLK      in   1       system clock
//  RESET    in   1       synchronous, active-high reset
//  ENABLE   in   1       clock enable; low = all state frozen
//  DATA_IN  in   DATA_W  value to send; sampled only on an accepted SEND
//  SEND     in   1       request; accepted when SEND & ENABLE & !BUSY
//  BUSY     out  1       high from the cycle after acceptance until message end
//  TX       out  1       UART line, idle high
// BEHAVIOUR
//  - Reset: TX=1, BUSY=0, all counters 0, FSM IDLE. Reset mid-frame aborts the message;
//    TX=1 and BUSY=0 on the cycle after RESET is sampled. No partial resume.
//  - Accept at cycle N: DATA_IN latched; BUSY=1 and TX=0 (start bit) from N+1.
//  - Message: NCHAR hex chars, most significant nibble first ('0'-'9'=0x30-0x39, 'A'-'F'=0x41-0x46),
//    then 0x0D, then 0x0A. NCHAR+2 frames, sent back to back with no idle gap.
//  - Frame: start(0), 8 data bits LSB first, [parity], stop(1); each bit exactly DIV enabled cycles.
//  - Bit FSM: IDLE -> START -> DATA(x8) -> [PARITY] -> STOP -> START (next char) or IDLE (after LF).
//  - Char index 0..NCHAR+1; it advances at the end of STOP. BUSY falls on the cycle after the
//    final enabled cycle of the LF stop bit. A SEND in that same cycle is accepted (BUSY reads 0).
//  - SEND while BUSY=1 is ignored. It is not queued.
//  - DATA_IN changes after acceptance have no effect.
//  - ENABLE=0: baud counter, FSM and TX hold their values. The current bit stretches by the
//    number of disabled cycles. SEND is not accepted while ENABLE=0. RESET acts regardless of ENABLE.
//  - Baud counter counts 0..DIV-1 and wraps at the bit boundary. Its width is $clog2(DIV).
//  - Frame time = 10*DIV cycles (11*DIV with parity). Message = (NCHAR+2) frames.
// CONFIGURATION
//  SERIAL_TX_PARITY_EN defined: an even-parity bit (XOR of the 8 data bits) is inserted
//    between DATA and STOP. Frame becomes 11 bits (8E1).
//  Undefined: no PARITY state, 8N1, 10 bits per frame.
// STRUCTURE
//  Shared package serial_pkg:
//    - ASCII_CR / ASCII_LF constants
//    - function hex_ascii(nibble) -> byte
//    - function baud_div(clk_freq, baud)
//    - bit-FSM state enum, shared with the receiver
//  Sub-module uart_tx_byte:
//    - inputs: byte, valid
//    - outputs: ready, TX
//    - owns the baud counter and bit FSM
//  serial_hex_tx itself holds the payload register, char index and the hex/CR/LF mux.
// TESTING (bench: CLK_FREQ=16, BAUD=1 -> DIV=16)
//  1. DATA_IN=16'h1A2F, SEND for 1 cycle -> TX decodes 0x31,0x41,0x32,0x46,0x0D,0x0A;
//     BUSY high for exactly 6*160 cycles.
//  2. SEND pulsed again at frame 2 while BUSY -> ignored, still exactly 6 chars;
//     a SEND on the cycle BUSY falls starts a new message.
//  3. RESET asserted mid-data bit of char 3 -> next cycle TX=1, BUSY=0;
//     a new SEND then restarts from the first char.
//  4. ENABLE low for 5 cycles mid-start-bit -> that bit lasts 21 cycles, all others 16;
//     decoded bytes unchanged.
//  5. DATA_IN changed to 16'hFFFF one cycle after acceptance of 16'h0000 -> sends "0000"CRLF.
//  6. SERIAL_TX_PARITY_EN, DATA_IN=16'h1000 -> '1' (0x31) parity=1, '0' (0x30) parity=0,
//     CR parity=1, LF parity=0; frames 176 cycles.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared serial-line definitions: ASCII framing constants, hex encoding, baud divider
// and the bit-level FSM state encoding used by both transmitter and receiver.
package serial_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [2:0] {
        BitIdle,
        BitStart,
        BitData,
        BitParity,
        BitStop
    } bit_state_e;

    // Uppercase hex: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46.
    function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
        if (nibble < 4'd10) begin
            return 8'h30 + {4'h0, nibble};
        end
        return 8'h37 + {4'h0, nibble};
    endfunction

    function automatic int unsigned baud_div(input int unsigned clk_freq,
                                             input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte UART transmitter: start, 8 data bits LSB first, optional even parity, stop.
// Define SERIAL_TX_PARITY_EN for 8E1 framing; default is 8N1.
module uart_tx_byte
    import serial_pkg::*;
#(
    parameter int unsigned DIV = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    bit_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    data_q, data_d;
    logic          bit_end;

    assign bit_end = (cnt_q == CNT_MAX);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        data_d  = data_q;
        ready   = 1'b0;
        if (enable) begin
            if (state_q != BitIdle) begin
                cnt_d = bit_end ? '0 : cnt_q + 1'b1;
            end
            unique case (state_q)
                BitIdle: begin
                    ready = 1'b1;
                    if (valid) begin
                        data_d  = data;
                        state_d = BitStart;
                    end
                end
                BitStart: begin
                    if (bit_end) begin
                        bit_d   = 3'd0;
                        state_d = BitData;
                    end
                end
                BitData: begin
                    if (bit_end) begin
                        if (bit_q == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
                            state_d = BitParity;
`else
                            state_d = BitStop;
`endif
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                BitParity: begin
                    if (bit_end) begin
                        state_d = BitStop;
                    end
                end
`endif
                BitStop: begin
                    // Last stop cycle doubles as a load slot so frames run back to back.
                    if (bit_end) begin
                        ready = 1'b1;
                        if (valid) begin
                            data_d  = data;
                            state_d = BitStart;
                        end else begin
                            state_d = BitIdle;
                        end
                    end
                end
                default: state_d = BitIdle;
            endcase
        end
    end

    always_comb begin
        tx = 1'b1;
        unique case (state_q)
            BitStart:  tx = 1'b0;
            BitData:   tx = data_q[bit_q];
            BitParity: tx = ^data_q;
            default:   tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BitIdle;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/serial_hex_tx.sv
// Sends a latched DATA_W-bit value as uppercase ASCII hex followed by CR LF over a UART line.
// Define SERIAL_TX_PARITY_EN to add an even-parity bit to every frame (8E1).
module serial_hex_tx
    import serial_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 9600,
    parameter int unsigned DATA_W   = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ENABLE,
    input  logic [DATA_W-1:0] DATA_IN,
    input  logic              SEND,
    output logic              BUSY,
    output logic              TX
);

    localparam int unsigned NCHAR = DATA_W / 4;
    localparam int unsigned NMSG  = NCHAR + 2;
    localparam int unsigned DIV   = baud_div(CLK_FREQ, BAUD);
    localparam int unsigned IW    = $clog2(NMSG);
    localparam logic [IW-1:0] LAST_IDX = IW'(NMSG - 1);

    logic [DATA_W-1:0] payload_q, payload_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              busy_q, busy_d;
    logic              accept, more, step;
    logic              tx_valid, tx_ready;
    logic [7:0]        tx_byte;

    // Message position idx -> character: hex digits MSB first, then CR, then LF.
    function automatic logic [7:0] msg_char(input logic [IW-1:0] idx,
                                            input logic [DATA_W-1:0] value);
        int unsigned       i;
        logic [DATA_W-1:0] sh;
        i  = 32'(idx);
        sh = value << (4 * i);
        if (i < NCHAR) begin
            return hex_ascii(sh[DATA_W-1 -: 4]);
        end else if (i == NCHAR) begin
            return ASCII_CR;
        end
        return ASCII_LF;
    endfunction

    assign accept   = SEND & ENABLE & ~busy_q;
    assign more     = busy_q && (idx_q != LAST_IDX);
    assign step     = busy_q & tx_ready;
    assign tx_valid = accept | more;
    // The first character comes straight from DATA_IN so the start bit begins at N+1.
    assign tx_byte  = accept ? msg_char('0, DATA_IN) : msg_char(idx_q + 1'b1, payload_q);

    always_comb begin
        payload_d = payload_q;
        idx_d     = idx_q;
        busy_d    = busy_q;
        if (accept) begin
            payload_d = DATA_IN;
            idx_d     = '0;
            busy_d    = 1'b1;
        end else if (step) begin
            if (more) begin
                idx_d = idx_q + 1'b1;
            end else begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            payload_q <= '0;
            idx_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            payload_q <= payload_d;
            idx_q     <= idx_d;
            busy_q    <= busy_d;
        end
    end

    uart_tx_byte #(
        .DIV(DIV)
    ) u_tx (
        .clk   (CLK),
        .reset (RESET),
        .enable(ENABLE),
        .data  (tx_byte),
        .valid (tx_valid),
        .ready (tx_ready),
        .tx    (TX)
    );

    assign BUSY = busy_q;

endmodule

// File: tb/tb_serial_hex_tx.sv
// Directed bench for serial_hex_tx at DIV=16: decodes the UART line and checks timing.
module tb_serial_hex_tx;

    localparam int unsigned CLK_FREQ = 16;
    localparam int unsigned BAUD     = 1;
`ifdef SERIAL_TX_PARITY_EN
    localparam int FRAME = 176;
`else
    localparam int FRAME = 160;
`endif
    localparam int MSG = 6 * FRAME;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] data_in;
    logic        send;
    logic        busy;
    logic        tx;

    int          checks = 0;
    int          failures = 0;
    int          busy_cycles = 0;
    logic [5:0]  last_par;

    serial_hex_tx #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD),
        .DATA_W  (16)
    ) dut (
        .CLK    (clk),
        .RESET  (rst),
        .ENABLE (en),
        .DATA_IN(data_in),
        .SEND   (send),
        .BUSY   (busy),
        .TX     (tx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (busy === 1'b1) busy_cycles <= busy_cycles + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (tx === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    // Entry: at the middle of bit position k0-1 (0 = start, 1..8 = data). Exit: mid stop bit.
    task automatic recv_tail(input int k0, inout logic [7:0] b, output logic par);
        for (int p = k0; p <= 8; p++) begin
            tick(16);
            b[p-1] = tx;
        end
        par = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        tick(16);
        par = tx;
        check_eq("parity", par, ^b);
`endif
        tick(16);
        check_eq("stop", tx, 1);
    endtask

    task automatic recv_frame(output logic [7:0] b, output logic par);
        bit ok;
        b   = 8'h00;
        par = 1'b0;
        wait_start(ok);
        check_eq("start_seen", ok, 1);
        if (ok) begin
            tick(7);
            check_eq("start_mid", tx, 0);
            recv_tail(1, b, par);
        end
    endtask

    task automatic recv_msg(input string tag, input logic [47:0] exp, input int first,
                            input int stop, input int pulse_after);
        logic [7:0] b;
        logic       p;
        for (int k = first; k < stop; k++) begin
            recv_frame(b, p);
            last_par[k] = p;
            check_eq(tag, b, exp[47-8*k -: 8]);
            if (k == pulse_after) begin
                send = 1'b1;
                tick(1);
                send = 1'b0;
            end
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            tick(1);
            n++;
        end
        check_eq("idle_reached", busy, 0);
    endtask

    task automatic start_msg(input logic [15:0] v);
        data_in = v;
        send    = 1'b1;
        tick(1);
        send    = 1'b0;
        check_eq("accept_busy", busy, 1);
        check_eq("accept_tx", tx, 0);
    endtask

    initial begin
        int         b0;
        int         n;
        int         len;
        bit         ok;
        logic [7:0] b;
        logic       p;

        rst = 1'b1; en = 1'b1; send = 1'b0; data_in = 16'h0000;
        last_par = 6'h00;
        tick(3);
        check_eq("reset_tx", tx, 1);
        check_eq("reset_busy", busy, 0);
        rst = 1'b0;
        tick(2);

        // SEND is not accepted while ENABLE is low.
        en = 1'b0; data_in = 16'h1A2F; send = 1'b1;
        tick(2);
        check_eq("disabled_send_busy", busy, 0);
        check_eq("disabled_send_tx", tx, 1);
        send = 1'b0; en = 1'b1;
        tick(2);

        // 1: basic message and BUSY duration.
        b0 = busy_cycles;
        start_msg(16'h1A2F);
        recv_msg("t1_char", 48'h31_41_32_46_0D_0A, 0, 6, -1);
        wait_idle(n);
        check_eq("t1_tail", n, 9);
        check_eq("t1_busy_len", busy_cycles - b0, MSG);

        // 2: SEND during BUSY ignored; SEND on the cycle BUSY falls is accepted.
        tick(3);
        b0 = busy_cycles;
        start_msg(16'hBEEF);
        recv_msg("t2_char", 48'h42_45_45_46_0D_0A, 0, 6, 1);
        wait_idle(n);
        check_eq("t2_tail", n, 9);
        check_eq("t2_busy_len", busy_cycles - b0, MSG);
        b0 = busy_cycles;
        start_msg(16'h0123);
        recv_msg("t2_next_char", 48'h30_31_32_33_0D_0A, 0, 6, -1);
        wait_idle(n);
        check_eq("t2_next_busy_len", busy_cycles - b0, MSG);

        // 3: reset in data bit 2 of char 3 ('2' = 0x32, that bit is 0).
        tick(3);
        start_msg(16'h1A2F);
        recv_msg("t3_char", 48'h31_41_32_46_0D_0A, 0, 2, -1);
        wait_start(ok);
        check_eq("t3_start_seen", ok, 1);
        tick(7 + 48);
        check_eq("t3_pre_reset_tx", tx, 0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_eq("t3_reset_tx", tx, 1);
        check_eq("t3_reset_busy", busy, 0);
        tick(20);
        check_eq("t3_quiet_tx", tx, 1);
        check_eq("t3_quiet_busy", busy, 0);
        b0 = busy_cycles;
        start_msg(16'h1A2F);
        recv_msg("t3_restart_char", 48'h31_41_32_46_0D_0A, 0, 6, -1);
        wait_idle(n);
        check_eq("t3_busy_len", busy_cycles - b0, MSG);

        // 4: ENABLE low 5 cycles mid start bit stretches only that bit.
        tick(3);
        b0 = busy_cycles;
        start_msg(16'h1A2F);
        tick(7);
        en = 1'b0;
        tick(5);
        en = 1'b1;
        len = 13;
        while (tx === 1'b0 && len < 60) begin
            tick(1);
            len++;
        end
        check_eq("t4_start_len", len - 1, 21);
        len = 1;
        while (tx === 1'b1 && len < 60) begin
            tick(1);
            len++;
        end
        check_eq("t4_bit0_len", len - 1, 16);
        b = 8'h01;
        tick(7);
        b[1] = tx;
        recv_tail(3, b, p);
        last_par[0] = p;
        check_eq("t4_char", b, 8'h31);
        recv_msg("t4_char", 48'h31_41_32_46_0D_0A, 1, 6, -1);
        wait_idle(n);
        check_eq("t4_busy_len", busy_cycles - b0, MSG + 5);

        // 5: DATA_IN changes after acceptance are not seen.
        tick(3);
        b0 = busy_cycles;
        start_msg(16'h0000);
        data_in = 16'hFFFF;
        recv_msg("t5_char", 48'h30_30_30_30_0D_0A, 0, 6, -1);
        wait_idle(n);
        check_eq("t5_busy_len", busy_cycles - b0, MSG);

`ifdef SERIAL_TX_PARITY_EN
        // 6: even parity per frame: '1'=1, '0'=0, CR=1, LF=0.
        tick(3);
        b0 = busy_cycles;
        start_msg(16'h1000);
        recv_msg("t6_char", 48'h31_30_30_30_0D_0A, 0, 6, -1);
        check_eq("t6_parity_bits", last_par, 6'b010001);
        wait_idle(n);
        check_eq("t6_busy_len", busy_cycles - b0, 1056);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
